// File: rtl/memarb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memarb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    localparam logic P_CPU  = 1'b0;
    localparam logic P_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester handshakes plus the single-port memory bus, bundled for the arbiter.
interface memory_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) ();
    logic              req0, we0, ack0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic              req1, we1, ack1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data, mem_q;
    logic              mem_wr_en;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
        output ack0, rdata0, ack1, rdata1, mem_addr, mem_data, mem_wr_en, busy
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
        input  ack0, rdata0, ack1, rdata1, mem_addr, mem_data, mem_wr_en, busy
    );
endinterface

// File: rtl/memarb_rr2.sv
// Two-way grant pick; round-robin on ties, or port 0 always first when
// MEMARB_FIXED_PRIO_EN is defined.
module memarb_rr2
    import memarb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_valid
);

`ifdef MEMARB_FIXED_PRIO_EN
    wire w_unused_last_grant = i_last_grant;

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = P_CPU;
        if (!i_req0 && i_req1)
            o_grant = P_LOAD;
    end
`else
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = P_CPU;
        if (i_req0 && i_req1)
            o_grant = ~i_last_grant;
        else if (i_req1)
            o_grant = P_LOAD;
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one single-port memory between a CPU port and a loader port,
// one access per grant (IDLE -> SERVE -> ACK). Tie policy: see MEMARB_FIXED_PRIO_EN.
//   state | meaning
//   IDLE  | pick a winner and latch its request
//   SERVE | drive the memory; write commits / read captured at closing edge
//   ACK   | pulse the winner's ack, remember it as last grant
module memory_arbiter
    import memarb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    memory_arbiter_if.slave  bus
);

    state_t            r_state, w_next;
    logic              r_last_grant, r_id, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
    logic              w_grant, w_valid;

    memarb_rr2 u_rr2 (
        .i_req0       (bus.req0),
        .i_req1       (bus.req1),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_valid)
    );

    always_ff @(posedge Clock) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = SERVE;
            SERVE:   w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_last_grant <= P_LOAD;
            r_id         <= P_CPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_id    <= w_grant;
                        r_we    <= w_grant ? bus.we1    : bus.we0;
                        r_addr  <= w_grant ? bus.addr1  : bus.addr0;
                        r_wdata <= w_grant ? bus.wdata1 : bus.wdata0;
                    end
                end
                SERVE: begin
                    if (!r_we) begin
                        if (r_id == P_LOAD)
                            r_rdata1 <= bus.mem_q;
                        else
                            r_rdata0 <= bus.mem_q;
                    end
                end
                ACK:     r_last_grant <= r_id;
                default: ;
            endcase
        end
    end

    // Reset gates the write enable so a write caught mid-SERVE never commits.
    assign bus.mem_wr_en = (r_state == SERVE) && r_we && !Reset;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_data  = r_wdata;
    assign bus.ack0      = (r_state == ACK) && (r_id == P_CPU);
    assign bus.ack1      = (r_state == ACK) && (r_id == P_LOAD);
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one single-port 32x16 memory between two requesters: port 0 = processor, port 1 = loader/debug port.
- The memory has combinational read and a write on the rising clock edge.
- The block arbitrates with a req/ack handshake, sequences one access per grant, and drives the memory's addr/data/wr_en.
- It registers the read data back to the winning requester. It sits between the processor/loader and the main memory instance.

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 16, memory word width.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until ack0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DATA_W  port 0 read data, valid when ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1  same widths and meaning for port 1.
- mem_addr  out  ADDR_W  to the memory address input.
- mem_data  out  DATA_W  to the memory write-data input.
- mem_wr_en  out  1  to the memory write enable.
- mem_q  in  DATA_W  from the memory read output.
- busy  out  1  high while state != IDLE.

Behaviour:
- Clocking/reset: one clock, Clock. Reset is synchronous and active-high, named Reset.
- Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - ack0=ack1=0, rdata0=rdata1=0, busy=0.
  - mem_addr=0, mem_data=0, mem_wr_en=0.
- States and transitions:
  - IDLE: if any req is high, latch the winner's id, we, addr and wdata, then go to SERVE. Otherwise stay in IDLE.
  - SERVE (exactly 1 cycle): mem_addr/mem_data come from the latched values; mem_wr_en = latched we.
    - Write: the memory commits at the closing edge of SERVE.
    - Read: mem_q is captured into the winner's rdata register at that same edge.
    - Then go to ACK.
  - ACK (1 cycle): the winner's ack=1 and its rdata is valid; the loser's ack=0; last_grant = winner. Then go to IDLE.
- Latency and throughput:
  - Request first seen in IDLE at cycle k: SERVE at k+1, ack at k+2.
  - Maximum throughput is 1 access per 3 cycles.
- Arbitration: only one requester high -> it wins. Both high in IDLE -> the port != last_grant wins (round-robin).
- Handshake rules:
  - A req still high during its ACK cycle is a new request, evaluated in the following IDLE. The requester drops req in the ACK cycle to avoid a repeat.
  - Changes to addr/we/wdata after IDLE latches them do not affect the in-flight access.
  - A requester dropping req before ack does not abort the access; it completes and ack is still pulsed.
- Outputs outside SERVE: mem_wr_en=0. mem_addr holds the last latched address, so mem_q follows it.
- rdata registers: hold their value until the next read by the same port. Writes leave rdata unchanged.
- Reset mid-operation: mem_wr_en is forced 0 in any cycle where Reset=1, so a SERVE write coinciding with Reset is not committed. The state returns to IDLE with no ack.
- Simultaneous case: the loser's req stays pending and is granted in the next IDLE cycle, so it cannot be starved by the other port.

Optional Feature:
- Macro: MEMARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both request. last_grant is still kept but ignored, so port 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Package memarb_pkg:
  - state enum {IDLE, SERVE, ACK} (2-bit encoding);
  - ADDR_W/DATA_W defaults;
  - port id constants P_CPU=0, P_LOAD=1.
- One natural sub-module, memarb_rr2: combinational 2-way pick from (req0, req1, last_grant) -> grant id plus a valid flag. The fixed-priority macro lives inside it.

Test Plan:
- Port 1 write: req1=1, we1=1, addr1=5'h1a, wdata1=16'h0123 -> mem_wr_en=1 only in SERVE with mem_addr=1a; ack1 at k+2; Mem[1a]=0123.
- Port 0 read-back: port 0 reads 5'h1a after that write -> ack0 at k+2 with rdata0=16'h0123; mem_wr_en stays 0.
- Contention: req0 and req1 high together from reset, both held -> grants 0,1,0,1, each ack 3 cycles apart. With MEMARB_FIXED_PRIO_EN, only ack0 pulses.
- Early drop: req0 dropped the cycle after IDLE latches a write of 16'hf000 to 5'h0 -> write still committed and ack0 still pulses.
- Reset in SERVE: Reset=1 during a SERVE write of 16'hbeef to 5'h3 -> Mem[3] unchanged; next cycle state=IDLE, all acks 0, rdata0/rdata1=0.
